// File: rtl/fetch_unit_if.sv
// Program-memory read bus between fetch_unit (master) and instruction memory (slave).
interface fetch_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (output mem_req, mem_addr, input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from program memory, instruction register.
// Optional return-address stack enabled by defining FETCH_CALL_STACK_EN.
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_inc,
  input  logic               halt,
  fetch_unit_if.master       bus,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               stack_err
);

  typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_HALTED} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_inc, seq_pc, next_pc;

  assign pc_inc = pc + PC_W'(1);
  assign seq_pc = s_inc ? pc_inc : instr[PC_W-1:0];
  assign opcode = instr[INSTR_W-1 -: 6];

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_RST;
    else       state <= state_nx;

  // Outputs decode straight from state so reset drops mem_req without waiting for an edge.
  always_comb begin
    state_nx     = state;
    bus.mem_req  = 1'b0;
    bus.mem_addr = pc;
    instr_valid  = 1'b0;
    case (state)
      S_RST:    state_nx = S_FETCH;
      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) state_nx = S_EXEC;
      end
      S_EXEC: begin
        instr_valid = 1'b1;
        state_nx    = halt ? S_HALTED : S_FETCH;
      end
      S_HALTED: if (!halt) state_nx = S_FETCH;
      default:  state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc    <= '0;
      instr <= '0;
    end else begin
      if (state == S_FETCH && bus.mem_ack) instr <= bus.mem_rdata;
      if (state == S_EXEC)                 pc    <= next_pc;
    end

`ifdef FETCH_CALL_STACK_EN
  localparam logic [5:0] OP_CALL = 6'b001000;
  localparam logic [5:0] OP_RET  = 6'b001001;

  // Ring of 4: top points at the newest entry, so a push when full lands on the oldest.
  logic [PC_W-1:0] stk [4];
  logic [1:0]      top, top_nx;
  logic [2:0]      cnt;
  logic            is_call, is_ret;

  assign is_call = (opcode == OP_CALL);
  assign is_ret  = (opcode == OP_RET);
  assign top_nx  = top + 2'd1;

  always_comb begin
    next_pc = seq_pc;
    if (is_call)     next_pc = instr[PC_W-1:0];
    else if (is_ret) next_pc = (cnt == 3'd0) ? '0 : stk[top];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      top       <= '0;
      cnt       <= '0;
      stack_err <= 1'b0;
      for (int i = 0; i < 4; i++) stk[i] <= '0;
    end else if (state == S_EXEC) begin
      if (is_call) begin
        top         <= top_nx;
        stk[top_nx] <= pc_inc;
        if (cnt == 3'd4) stack_err <= 1'b1;
        else             cnt       <= cnt + 3'd1;
      end else if (is_ret) begin
        if (cnt == 3'd0) stack_err <= 1'b1;
        else begin
          top <= top - 2'd1;
          cnt <= cnt - 3'd1;
        end
      end
    end
`else
  assign next_pc   = seq_pc;
  assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-driven memory responder plus PC/stack reference model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_inc = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [9:0]  pc;
  logic        stack_err;

  fetch_unit_if #(.PC_W(10), .INSTR_W(16)) bus ();

  fetch_unit #(.PC_W(10), .INSTR_W(16)) dut (
    .clk(clk), .reset(reset), .s_inc(s_inc), .halt(halt), .bus(bus),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mem [1024];
  logic [9:0]  exp_pc;
  bit          exp_err;
  logic [9:0]  stk_q [$];

  task automatic model_reset();
    exp_pc  = '0;
    exp_err = 1'b0;
    stk_q.delete();
  endtask

  // One instruction: FETCH with lat wait cycles, then EXEC; halt rises from FETCH cycle hlt_at.
  task automatic run_instr(input int lat, input bit sinc, input int hlt_at);
    logic [15:0] w;
    logic [9:0]  nxt;
    w = mem[exp_pc];
    for (int i = 0; i <= lat; i++) begin
      n_vec++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_pc || instr_valid !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_cyc%0d: req=%b addr=%h vld=%b, expected req=1 addr=%h vld=0",
                 i, bus.mem_req, bus.mem_addr, instr_valid, exp_pc);
      end
      bus.mem_ack   = (i == lat);
      bus.mem_rdata = (i == lat) ? w : 16'($urandom);
      if (hlt_at >= 0 && i >= hlt_at) halt = 1'b1;
      @(negedge clk);
    end
    // Stray ack with garbage during EXEC must not reload instr.
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    s_inc         = sinc;
    n_vec++;
    if (instr_valid !== 1'b1 || instr !== w || opcode !== w[15:10] || bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL exec: vld=%b instr=%h op=%h req=%b, expected vld=1 instr=%h op=%h req=0",
               instr_valid, instr, opcode, bus.mem_req, w, w[15:10]);
    end
    nxt = sinc ? exp_pc + 10'd1 : w[9:0];
`ifdef FETCH_CALL_STACK_EN
    if (w[15:10] == 6'b001000) begin
      stk_q.push_back(exp_pc + 10'd1);
      if (stk_q.size() > 4) begin
        stk_q.pop_front();
        exp_err = 1'b1;
      end
      nxt = w[9:0];
    end else if (w[15:10] == 6'b001001) begin
      if (stk_q.size() == 0) begin
        nxt     = '0;
        exp_err = 1'b1;
      end else nxt = stk_q.pop_back();
    end
`endif
    @(negedge clk);
    bus.mem_ack = 1'b0;
    exp_pc = nxt;
    n_vec++;
    if (pc !== exp_pc || stack_err !== exp_err || instr !== w || instr_valid !== 1'b0 ||
        bus.mem_req !== !halt) begin
      n_err++;
      $display("FAIL post_exec: pc=%h err=%b instr=%h vld=%b req=%b, expected pc=%h err=%b instr=%h vld=0 req=%b",
               pc, stack_err, instr, instr_valid, bus.mem_req, exp_pc, exp_err, w, !halt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; halt = 1'b0; s_inc = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    #2;
    n_vec++;
    if (bus.mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 10'd0 || instr !== 16'd0 ||
        stack_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: req=%b vld=%b pc=%h instr=%h err=%b, expected all 0",
               bus.mem_req, instr_valid, pc, instr, stack_err);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL rst_state: req=%b, expected 0", bus.mem_req);
    end
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) run_instr(0, 1'b1, -1);
  endtask

  task automatic test_wait();
    if (exp_pc != 10'd5) run_instr(0, 1'b1, -1);
    run_instr(3, 1'b1, -1);
  endtask

  task automatic test_jump_wrap();
    mem[exp_pc] = 16'h1023;
    run_instr(0, 1'b0, -1);
    mem[exp_pc] = 16'h0BFF;
    run_instr(1, 1'b0, -1);
    run_instr(0, 1'b1, -1);
    run_instr(0, 1'b1, -1);
  endtask

  task automatic test_halt();
    logic [15:0] held;
    while (exp_pc != 10'd2) run_instr(0, 1'b1, -1);
    run_instr(2, 1'b1, 1);
    held = instr;
    for (int k = 0; k < 3; k++) begin
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'($urandom);
      n_vec++;
      if (bus.mem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 10'd3 || instr !== held) begin
        n_err++;
        $display("FAIL halted: req=%b vld=%b pc=%h instr=%h, expected req=0 vld=0 pc=003 instr=%h",
                 bus.mem_req, instr_valid, pc, instr, held);
      end
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    halt = 1'b0;
    @(negedge clk);
    run_instr(0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_fetch();
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    #1 reset = 1'b1;
    #1;
    n_vec++;
    if (bus.mem_req !== 1'b0 || pc !== 10'd0 || instr !== 16'd0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: req=%b pc=%h instr=%h vld=%b, expected all 0",
               bus.mem_req, pc, instr, instr_valid);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    run_instr(0, 1'b1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++)
      run_instr(int'($urandom_range(0, 3)), 1'($urandom), -1);
  endtask

`ifdef FETCH_CALL_STACK_EN
  task automatic test_call_stack();
    test_reset();
    mem[0] = {6'd2, 10'h010};
    run_instr(0, 1'b0, -1);
    mem[10'h010] = {6'b001000, 10'h040};
    mem[10'h040] = {6'b001001, 10'h155};
    run_instr(0, 1'b1, -1);
    run_instr(1, 1'b1, -1);
    for (int k = 0; k < 5; k++) mem[10'h011 + 10'(k)] = {6'b001000, 10'h012 + 10'(k)};
    for (int k = 0; k < 5; k++) run_instr(0, 1'($urandom), -1);
    test_reset();
    mem[0] = {6'b001001, 10'h2AA};
    run_instr(0, 1'b1, -1);
    run_instr(0, 1'b1, -1);
  endtask
`endif

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    model_reset();
    test_reset();
    test_sequential();
    test_wait();
    test_jump_wrap();
    test_halt();
    test_reset_mid_fetch();
    test_random();
`ifdef FETCH_CALL_STACK_EN
    test_call_stack();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
